// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock/baud divider.
// The default divisor gives 115200 baud from a 50 MHz clock.
package clk_div_pkg;

  localparam int DIV_MIN          = 2;
  localparam int DIV_BAUD_DEFAULT = 434;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/clk_div_core.sv
// Period counter for the divider plus the phase comparators that
// locate the rise, fall and mid-period points within one period.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             advance,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] h,
  input  logic [WIDTH-1:0] q,
  output logic             wrap,
  output logic             hi,
  output logic             at_zero,
  output logic             at_h,
  output logic             at_q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] n_m1;

  assign n_m1    = n - WIDTH'(1);
  assign wrap    = (cnt_q == n_m1);
  assign hi      = (cnt_q < h);
  assign at_zero = (cnt_q == '0);
  assign at_h    = (cnt_q == h);
  assign at_q    = (cnt_q == q);

  // Anything other than a running cycle parks the counter at zero, so a
  // restart is always phase-aligned to enable.
  always_comb begin
    cnt_d = '0;
    if (advance) begin
      cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider: divisor handshake with a one-entry
// pending register applied only on period boundaries, run/idle FSM, strobes.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DIV_RESET = DIV_BAUD_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic [WIDTH-1:0] div_active,
  output logic             new_clk,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             mid_pulse
);

  localparam logic [WIDTH-1:0] DIV_RST_V = WIDTH'(DIV_RESET);
  localparam logic [WIDTH-1:0] H_RST     = DIV_RST_V - (DIV_RST_V >> 1);
  localparam logic [WIDTH-1:0] Q_RST     = DIV_RST_V >> 2;
  localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(DIV_MIN);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] h_q, h_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             div_ready_q, div_ready_d;
  logic             new_clk_q, new_clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             mid_q, mid_d;

  logic advance;
  logic wrap, hi, at_zero, at_h, at_q;
  logic accept, apply;

  assign advance = (state_q == ST_RUN) && enable;
  assign accept  = div_valid && div_ready_q;
  assign apply   = pend_valid_q && ((state_q == ST_IDLE) || (advance && wrap));

  clk_div_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk    (clk),
    .rstn   (rstn),
    .advance(advance),
    .n      (div_active_q),
    .h      (h_q),
    .q      (q_q),
    .wrap   (wrap),
    .hi     (hi),
    .at_zero(at_zero),
    .at_h   (at_h),
    .at_q   (at_q)
  );

  always_comb begin
    state_d      = state_q;
    div_active_d = div_active_q;
    h_d          = h_q;
    q_d          = q_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    new_clk_d    = 1'b0;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    mid_d        = 1'b0;

    // accept needs an empty pending slot, so it never coincides with apply.
    if (accept) begin
      pend_d       = (div_in < MIN_V) ? MIN_V : div_in;
      pend_valid_d = 1'b1;
    end else if (apply) begin
      pend_valid_d = 1'b0;
    end

    if (apply) begin
      div_active_d = pend_q;
      h_d          = pend_q - (pend_q >> 1);
      q_d          = pend_q >> 2;
    end

    div_ready_d = !pend_valid_d;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (enable) begin
          new_clk_d = hi;
          rise_d    = at_zero;
          fall_d    = at_h;
          mid_d     = at_q;
        end else begin
          state_d = ST_IDLE;
          fall_d  = new_clk_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      div_active_q <= DIV_RST_V;
      h_q          <= H_RST;
      q_q          <= Q_RST;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      div_ready_q  <= 1'b1;
      new_clk_q    <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      mid_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_active_q <= div_active_d;
      h_q          <= h_d;
      q_q          <= q_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      div_ready_q  <= div_ready_d;
      new_clk_q    <= new_clk_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      mid_q        <= mid_d;
    end
  end

  assign div_ready  = div_ready_q;
  assign div_active = div_active_q;
  assign new_clk    = new_clk_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign mid_pulse  = mid_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus pushes the expected outputs for
// each clock, a monitor pops and compares them one edge later.
module tb_clk_div_prog;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable;
  logic [15:0] div_in;
  logic        div_valid;
  logic        div_ready;
  logic [15:0] div_active;
  logic        new_clk;
  logic        rise_pulse;
  logic        fall_pulse;
  logic        mid_pulse;

  always #5 clk = ~clk;

  clk_div_prog #(
    .WIDTH    (16),
    .DIV_RESET(434)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .div_active(div_active),
    .new_clk   (new_clk),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .mid_pulse (mid_pulse)
  );

  typedef struct {
    logic [3:0]  pul;   // {new_clk, rise, fall, mid}
    logic        rdy;
    logic [15:0] act;
    logic [63:0] tag;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_cyc    = 0;
  logic last_nc  = 1'b0;

  // Expected strobes for period index k of divisor n.
  function automatic logic [3:0] pe(input int n, input int k);
    int h;
    h = n - n / 2;
    return {k < h, k == 0, k == h, k == n / 4};
  endfunction

  always @(posedge clk) begin
    #1;
    n_cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({new_clk, rise_pulse, fall_pulse, mid_pulse} !== e.pul ||
          div_ready !== e.rdy || div_active !== e.act) begin
        n_err++;
        $display("FAIL %s cyc=%0d clk/rise/fall/mid=%b ready=%b active=%0d, required %b ready=%b active=%0d",
                 e.tag, n_cyc, {new_clk, rise_pulse, fall_pulse, mid_pulse}, div_ready,
                 div_active, e.pul, e.rdy, e.act);
      end
    end
  end

  task automatic step(input logic rst, input logic en, input logic dv, input logic [15:0] din,
                      input logic [3:0] pul, input logic rdy, input logic [15:0] act,
                      input logic [63:0] tag);
    exp_t x;
    @(negedge clk);
    rstn      = rst;
    enable    = en;
    div_valid = dv;
    div_in    = din;
    x.pul = pul;
    x.rdy = rdy;
    x.act = act;
    x.tag = tag;
    exp_q.push_back(x);
    last_nc = pul[3];
  endtask

  task automatic run(input int n, input int k0, input int cnt, input logic [15:0] act,
                     input logic [63:0] tag);
    for (int i = 0; i < cnt; i++) step(1, 1, 0, 0, pe(n, (k0 + i) % n), 1, act, tag);
  endtask

  task automatic start(input logic [15:0] act);
    step(1, 1, 0, 0, 4'b0000, 1, act, "start");
  endtask

  // Leaving RUN: clock forced low, fall strobe only if it was high.
  task automatic stop(input logic [15:0] act);
    step(1, 0, 0, 0, {1'b0, 1'b0, last_nc, 1'b0}, 1, act, "stop");
  endtask

  // Load from IDLE: captured on one edge, applied on the next.
  task automatic load(input logic [15:0] din, input logic [15:0] act_old,
                      input logic [15:0] act_new);
    step(1, 0, 1, din, 4'b0000, 0, act_old, "ld");
    step(1, 0, 0, 0, 4'b0000, 1, act_new, "ld_apply");
  endtask

  initial begin
    rstn      = 1'b0;
    enable    = 1'b0;
    div_valid = 1'b0;
    div_in    = '0;

    step(0, 0, 0, 0, 4'b0000, 1, 434, "reset");
    step(0, 0, 0, 0, 4'b0000, 1, 434, "reset");
    step(1, 0, 0, 0, 4'b0000, 1, 434, "idle");

    // Default divisor: H=217, mid at 108, first rise one edge after enable.
    start(434);
    run(434, 0, 873, 434, "n434");
    stop(434);

    load(3, 434, 3);
    start(3);
    run(3, 0, 9, 3, "n3");
    stop(3);

    load(0, 3, 2);
    start(2);
    run(2, 0, 6, 2, "n2_from0");
    stop(2);

    // 10 -> 7 mid-period: request accepted on the edge that processes index 3,
    // ready low for indices 3..8, new divisor lands on the wrap edge.
    load(10, 2, 10);
    start(10);
    run(10, 0, 3, 10, "n10");
    step(1, 1, 1, 7, pe(10, 3), 0, 10, "chg");
    for (int k = 4; k < 9; k++)
      step(1, 1, (k == 5), (k == 5) ? 16'd99 : 16'd0, pe(10, k), 0, 10, "chg_wait");
    step(1, 1, 0, 0, pe(10, 9), 1, 7, "chg_wrap");
    run(7, 0, 14, 7, "n7");
    stop(7);

    load(1, 7, 2);
    start(2);
    run(2, 0, 4, 2, "n2_from1");
    stop(2);

    // Drop enable while high at index 2 of N=8, then restart aligned.
    load(8, 2, 8);
    start(8);
    run(8, 0, 3, 8, "n8");
    stop(8);
    step(1, 0, 0, 0, 4'b0000, 1, 8, "idle8");
    start(8);
    run(8, 0, 3, 8, "n8_re");
    step(1, 1, 1, 20, pe(8, 3), 0, 8, "pend20");
    step(1, 1, 0, 0, pe(8, 4), 0, 8, "pend20");

    // Reset with the counter at 5 and 20 still pending: pending must vanish.
    step(0, 1, 0, 0, 4'b0000, 1, 434, "rst_mid");
    step(1, 0, 0, 0, 4'b0000, 1, 434, "post_rst");
    step(1, 0, 0, 0, 4'b0000, 1, 434, "post_rst");
    start(434);
    run(434, 0, 4, 434, "n434_b");
    step(1, 0, 0, 0, {1'b0, 1'b0, last_nc, 1'b0}, 1, 434, "stop_end");

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain left=%0d required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
